// File: rtl/life_pass_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : life_pass_ctrl_if
//  Purpose  : Memory/shift control port between the pass sequencer and the
//             linear life engine (read/write addresses, strobes).
//  Revision : 1.0  initial release
// ============================================================================
interface life_pass_ctrl_if #(
  parameter int DBITS = 8
);
  logic [DBITS-1:0] raddr;
  logic [DBITS-1:0] waddr;
  logic             we;
  logic             sh;
  logic             ld;
  logic             init;

  modport master (output raddr, waddr, we, sh, ld, init);
  modport slave  (input  raddr, waddr, we, sh, ld, init);
endinterface
`default_nettype wire

// File: rtl/life_pass_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : life_pass_ctrl
//  Purpose  : Pass sequencer for the linear life engine. Streams one image
//             pass from the current bank through the engine, writes results
//             into the opposite bank, and arbitrates the engine read port
//             between pass reads, video row loads and host init writes.
//  Options  : LIFE_GEN_CNT_EN - enables the 32-bit generation counter.
//  Revision : 1.0  initial release
// ============================================================================
module life_pass_ctrl #(
  parameter int DBITS = 8,
  parameter int ROWS  = 128,
  parameter int GENS  = 1,
  parameter int WLAT  = 4
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              start,
  input  wire              run,
  output logic             busy,
  output logic             done,
  output logic             bank,
  input  wire              vid_req,
  input  wire  [DBITS-2:0] vid_row,
  output logic             vid_ack,
  output logic             vid_valid,
  input  wire              init_req,
  input  wire  [DBITS-2:0] init_row,
  output logic             init_ack,
  output logic [31:0]      gen_count,
  life_pass_ctrl_if.master eng
);

  localparam int RW   = DBITS - 1;
  localparam int LAST = ROWS + 2 * GENS - 1;
  localparam int SW   = $clog2(LAST + 1) + 1;
  localparam int DW   = (WLAT > 1) ? $clog2(WLAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     seq;
  logic [DW-1:0]     drain_cnt;
  logic              vid_won_prev;
  logic [2:0]        ld_pipe;
  logic [WLAT-1:0]   wp_valid;
  logic [RW-1:0]     wp_row [WLAT];

  logic              issue_ld;
  logic              issue_sh;
  logic              issue_init;
  logic              drain_end;
  logic [RW-1:0]     rd_row;
  logic [RW-1:0]     wr_row;
  logic              wr_ent;

  // Row arithmetic is modulo ROWS, so only the low RW bits of the index matter.
  assign rd_row = RW'(seq) + RW'(ROWS - GENS);
  assign wr_row = RW'(seq) - RW'(2 * GENS);
  assign wr_ent = issue_sh && (seq >= SW'(2 * GENS));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and read-port arbitration; everything idles while reset is low.
  always_comb begin
    state_nxt  = state;
    issue_ld   = 1'b0;
    issue_sh   = 1'b0;
    issue_init = 1'b0;
    drain_end  = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (init_req) begin
            issue_init = 1'b1;
          end else begin
            issue_ld = vid_req;
            if (start || run) state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          // Video yields after a win so the pass advances at least every other cycle.
          if (vid_req && !vid_won_prev) begin
            issue_ld = 1'b1;
          end else begin
            issue_sh = 1'b1;
            if (seq == SW'(LAST)) state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          issue_ld = vid_req;
          if (drain_cnt == DW'(WLAT - 1)) begin
            drain_end = 1'b1;
            state_nxt = run ? S_RUN : S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Engine port drive: reads from bank, pass writes to ~bank, init writes to bank.
  always_comb begin
    eng.sh    = issue_sh;
    eng.ld    = issue_ld;
    eng.init  = issue_init;
    eng.we    = issue_init | wp_valid[WLAT-1];
    eng.raddr = '0;
    eng.waddr = '0;
    if (issue_ld)      eng.raddr = {bank, vid_row};
    else if (issue_sh) eng.raddr = {bank, rd_row};
    if (issue_init)              eng.waddr = {bank, init_row};
    else if (wp_valid[WLAT-1])   eng.waddr = {~bank, wp_row[WLAT-1]};
  end

  assign busy      = (state != S_IDLE);
  assign vid_ack   = issue_ld;
  assign init_ack  = issue_init;
  assign vid_valid = ld_pipe[2];

  // Pass sequence index and drain timer; both restart whenever their state is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq       <= '0;
      drain_cnt <= '0;
    end else begin
      if (state != S_RUN) seq <= '0;
      else if (issue_sh)  seq <= seq + SW'(1);
      if (state != S_DRAIN) drain_cnt <= '0;
      else                  drain_cnt <= drain_cnt + DW'(1);
    end
  end

  // Bank flip and done pulse at the end of drain, when the last write has landed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= drain_end;
      if (drain_end) bank <= ~bank;
    end
  end

  // Video bookkeeping: fairness flag and the 3-cycle engine output latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_won_prev <= 1'b0;
      ld_pipe      <= '0;
    end else begin
      vid_won_prev <= issue_ld;
      ld_pipe      <= {ld_pipe[1:0], issue_ld};
    end
  end

  // Write pipeline: advances every cycle so video stalls only insert bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_valid <= '0;
      for (int i = 0; i < WLAT; i++) wp_row[i] <= '0;
    end else begin
      wp_valid[0] <= wr_ent;
      wp_row[0]   <= wr_row;
      for (int i = 1; i < WLAT; i++) begin
        wp_valid[i] <= wp_valid[i-1];
        wp_row[i]   <= wp_row[i-1];
      end
    end
  end

`ifdef LIFE_GEN_CNT_EN
  // Generation counter, updated together with the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         gen_count <= '0;
    else if (drain_end) gen_count <= gen_count + 32'(GENS);
  end
`else
  assign gen_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_pass_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_pass_ctrl
//  Purpose  : Self-checking bench for life_pass_ctrl (DBITS=8, ROWS=128,
//             GENS=1, WLAT=4). Honours LIFE_GEN_CNT_EN for gen_count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_life_pass_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       run;
  logic       busy;
  logic       done;
  logic       bank;
  logic       vid_req;
  logic [6:0] vid_row;
  logic       vid_ack;
  logic       vid_valid;
  logic       init_req;
  logic [6:0] init_row;
  logic       init_ack;
  logic [31:0] gen_count;

  int vectors    = 0;
  int miscompares = 0;
  int passes     = 0;

  life_pass_ctrl_if #(.DBITS(8)) eng ();

  life_pass_ctrl #(.DBITS(8), .ROWS(128), .GENS(1), .WLAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run),
    .busy(busy), .done(done), .bank(bank),
    .vid_req(vid_req), .vid_row(vid_row), .vid_ack(vid_ack), .vid_valid(vid_valid),
    .init_req(init_req), .init_row(init_row), .init_ack(init_ack),
    .gen_count(gen_count), .eng(eng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_gc();
`ifdef LIFE_GEN_CNT_EN
    return 32'(passes);
`else
    return 32'd0;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, eng.we, 0);
    chk({tag, "_sh"}, eng.sh, 0);
    chk({tag, "_ld"}, eng.ld, 0);
    chk({tag, "_init"}, eng.init, 0);
    chk({tag, "_raddr"}, eng.raddr, 0);
    chk({tag, "_waddr"}, eng.waddr, 0);
    chk({tag, "_vack"}, vid_ack, 0);
    chk({tag, "_vval"}, vid_valid, 0);
    chk({tag, "_iack"}, init_ack, 0);
    chk({tag, "_bank"}, bank, 0);
    chk({tag, "_gc"}, gen_count, 0);
  endtask

  // One pass started by a start pulse; checks read order, write order/timing,
  // video arbitration and the done cycle.
  task automatic do_pass(input bit vid_hold, input logic [6:0] vrow, input int exp_done);
    int   shn, wn, cyc;
    int   due[$];
    bit   ldh0, ldh1, ldh2, prev_ld, fin;
    logic b0, nb;
    logic [6:0] er;
    shn = 0; wn = 0; ldh0 = 0; ldh1 = 0; ldh2 = 0; prev_ld = 0; fin = 0;
    b0 = bank; nb = ~b0;
    start = 1'b1; vid_req = vid_hold; vid_row = vrow;
    for (cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      chk("ld_sh_excl", eng.ld & eng.sh, 0);
      if (done) begin
        passes++;
        fin = 1;
        chk("done_cycle", cyc, exp_done);
        chk("bank_toggle", bank, nb);
        chk("sh_count", shn, 130);
        chk("we_count", wn, 128);
        chk("due_empty", due.size(), 0);
        chk("gen_count", gen_count, exp_gc());
      end else begin
        if (vid_hold) begin
          chk("vid_valid", vid_valid, ldh2);
          chk("vid_ack", vid_ack, eng.ld);
          chk("vid_yield", eng.ld && prev_ld && busy && shn < 130, 0);
          if (eng.ld) chk("vid_raddr", eng.raddr, {b0, vrow});
        end
        if (eng.sh) begin
          er = 7'((shn + 127) % 128);
          chk("rd_addr", eng.raddr, {b0, er});
          if (shn >= 2) due.push_back(cyc + 4);
          shn++;
        end
        if (eng.we) begin
          if (due.size() == 0) chk("we_unexpected", 1, 0);
          else chk("we_cycle", cyc, due.pop_front());
          chk("wr_addr", eng.waddr, {nb, 7'(wn)});
          chk("wr_init", eng.init, 0);
          wn++;
        end
      end
      ldh2 = ldh1; ldh1 = ldh0; ldh0 = eng.ld; prev_ld = eng.ld;
      next_cycle();
      start = 1'b0;
    end
    if (!fin) chk("pass_timeout", 0, 1);
    vid_req = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_after", busy, 0);
    next_cycle();
  endtask

  typedef struct {
    logic       ireq;
    logic [6:0] irow;
    logic       vreq;
    logic [6:0] vrow;
    logic       st;
    logic       e_we;
    logic       e_init;
    logic       e_iack;
    logic [7:0] e_waddr;
    logic       e_ld;
    logic       e_vack;
    logic [7:0] e_raddr;
    logic       e_vval;
    logic       e_busy;
  } vec_t;

  vec_t tv [11];

  initial begin
    int   shn, dn, wn;
    bit   got, ack_busy;
    logic b, nb;

    // IDLE-state arbitration table (bank = 0)
    tv[0]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 7'd5,   1'b0, 7'd0,   1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 7'd0,   1'b1, 7'd33,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 7'd127, 1'b1, 7'd3,   1'b0, 1'b1, 1'b1, 1'b1, 8'h7f, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 7'd0,   1'b0, 7'd0,   1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 7'd0,   1'b1, 7'd127, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h7f, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 7'd0,   1'b1, 7'd64,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[10] = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

    reset = 1'b0; start = 1'b0; run = 1'b0; vid_req = 1'b0; vid_row = 7'd0;
    init_req = 1'b0; init_row = 7'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    next_cycle();
    reset = 1'b1;

    // Table-driven IDLE vectors
    for (int i = 0; i < 11; i++) begin
      init_req = tv[i].ireq; init_row = tv[i].irow;
      vid_req  = tv[i].vreq; vid_row  = tv[i].vrow;
      start    = tv[i].st;
      @(negedge clk);
      chk($sformatf("tv%0d_we", i),    eng.we,    tv[i].e_we);
      chk($sformatf("tv%0d_init", i),  eng.init,  tv[i].e_init);
      chk($sformatf("tv%0d_iack", i),  init_ack,  tv[i].e_iack);
      chk($sformatf("tv%0d_waddr", i), eng.waddr, tv[i].e_waddr);
      chk($sformatf("tv%0d_ld", i),    eng.ld,    tv[i].e_ld);
      chk($sformatf("tv%0d_vack", i),  vid_ack,   tv[i].e_vack);
      chk($sformatf("tv%0d_raddr", i), eng.raddr, tv[i].e_raddr);
      chk($sformatf("tv%0d_vval", i),  vid_valid, tv[i].e_vval);
      chk($sformatf("tv%0d_busy", i),  busy,      tv[i].e_busy);
      chk($sformatf("tv%0d_sh", i),    eng.sh,    0);
      next_cycle();
    end
    init_req = 1'b0; vid_req = 1'b0; start = 1'b0;
    repeat (4) next_cycle();

    // Reset asserted mid-pass right after index s=50 is issued
    start = 1'b1;
    shn = 0;
    for (int c = 0; c < 200 && shn < 51; c++) begin
      @(negedge clk);
      if (eng.sh) shn++;
      next_cycle();
      start = 1'b0;
    end
    chk("rstmid_reached", shn, 51);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rstmid");
    next_cycle();
    next_cycle();
    reset = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (eng.we || busy) got = 1;
      next_cycle();
    end
    chk("rstmid_quiet", got, 0);

    // Plain pass, bank 0 -> 1
    do_pass(1'b0, 7'd0, 135);
    // Pass with video held continuously, bank 1 -> 0
    do_pass(1'b1, 7'd77, 264);

    // Init request raised during RUN is deferred until IDLE (bank 0 -> 1)
    start = 1'b1;
    next_cycle();
    start = 1'b0; init_req = 1'b1; init_row = 7'd9;
    got = 0; ack_busy = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        passes++;
        chk("init_pass_gc", gen_count, exp_gc());
      end
      if (init_ack) begin
        got = 1;
        if (busy) ack_busy = 1;
        chk("init_waddr", eng.waddr, 8'h89);
        chk("init_we", eng.we, 1);
        chk("init_init", eng.init, 1);
        chk("init_done_cycle", done, 1);
      end
      next_cycle();
    end
    init_req = 1'b0;
    chk("init_served", got, 1);
    chk("init_while_busy", ack_busy, 0);
    @(negedge clk);
    chk("init_ack_pulse", init_ack, 0);
    next_cycle();

    // run held for three back-to-back passes, dropped during the third
    run = 1'b1;
    dn = 0; shn = 0; wn = 0; b = bank;
    for (int c = 0; c < 1000 && dn < 3; c++) begin
      @(negedge clk);
      if (eng.sh) shn++;
      if (eng.we) wn++;
      if (done) begin
        dn++;
        passes++;
        nb = ~b;
        chk("run_bank", bank, nb);
        chk("run_busy", busy, dn < 3);
        chk("run_gc", gen_count, exp_gc());
        b = nb;
      end
      next_cycle();
      if (dn == 2) run = 1'b0;
    end
    chk("run_dones", dn, 3);
    chk("run_sh_total", shn, 390);
    chk("run_we_total", wn, 384);
    @(negedge clk);
    chk("run_end_busy", busy, 0);
    chk("run_end_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
